// File: rtl/slow_pulse_gen_if.sv
// slow_pulse_gen_if
//   Bundle of the prescaler's control and result signals.
//   Handshake semantics: there is no valid/ready pair. The controller drives
//   en/clear/ch_sel level-sensitively; they are sampled on every rising clk
//   edge. count/level/tick are registered results, valid every cycle.
//   Signals:
//     en      count enable (counter holds when low)
//     clear   synchronous counter clear
//     ch_sel  per-channel tap index, channel i at [i*SEL_W +: SEL_W]
//     count   current prescaler value
//     level   registered square wave per channel
//     tick    one-cycle strobe per rising edge of level
//   Modports: master = controller side, slave = prescaler side.
interface slow_pulse_gen_if #(
  parameter int CNT_W  = 23,
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 5
) ();
  logic                    en;
  logic                    clear;
  logic [NUM_CH*SEL_W-1:0] ch_sel;
  logic [CNT_W-1:0]        count;
  logic [NUM_CH-1:0]       level;
  logic [NUM_CH-1:0]       tick;

  modport master (
    output en, clear, ch_sel,
    input  count, level, tick
  );

  modport slave (
    input  en, clear, ch_sel,
    output count, level, tick
  );
endinterface

// File: rtl/slow_pulse_gen.sv
// slow_pulse_gen
//   Free-running prescaler shared by NUM_CH channels. Each channel picks a
//   counter tap at runtime and produces a registered square wave (period
//   2^(sel+1) cycles while enabled) plus a one-cycle tick on each rising edge
//   of that wave. Taps at or beyond CNT_W read as constant 0.
//   Optional macro SLOW_PULSE_STATE_EN adds a small sequencer that advances
//   on every registered tick of channel 0 and exposes its state both binary
//   and one-hot.
//   Ports:
//     clk           rising-edge clock
//     rst           synchronous reset, active-high
//     state         sequencer state (SLOW_PULSE_STATE_EN only)
//     state_onehot  decoded sequencer state (SLOW_PULSE_STATE_EN only)
//     bus           slow_pulse_gen_if.slave: en, clear, ch_sel in;
//                   count, level, tick out
//   Priority at each edge: rst > clear > en > hold.
module slow_pulse_gen #(
  parameter int CNT_W      = 23,
  parameter int NUM_CH     = 2,
  parameter int SEL_W      = 5,
  parameter int NUM_STATES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SLOW_PULSE_STATE_EN
  output logic [SEL_W-1:0]      state,
  output logic [NUM_STATES-1:0] state_onehot,
`endif
  slow_pulse_gen_if.slave       bus
);

  // Sequencer length must fit the state field; checked at elaboration.
  if (NUM_STATES < 2 || NUM_STATES > (1 << SEL_W)) begin : g_bad_num_states
    $error("slow_pulse_gen: NUM_STATES out of range");
  end

  // The counter is zero-extended to cover every encodable tap index, so an
  // out-of-range select simply reads a constant-0 bit.
  localparam int EXT_W = ((1 << SEL_W) > CNT_W) ? (1 << SEL_W) : CNT_W;

  logic [CNT_W-1:0]  count_q;
  logic [EXT_W-1:0]  count_ext;
  logic [NUM_CH-1:0] tap_bit;
  logic [NUM_CH-1:0] level_q;
  logic [NUM_CH-1:0] tick_q;

  // Prescaler counter; wrap from all-ones to zero is ordinary modulo add.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.clear) begin
      count_q <= '0;
    end else if (bus.en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_ext = EXT_W'(count_q);

  always_comb begin
    tap_bit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tap_bit[i] = count_ext[bus.ch_sel[i*SEL_W +: SEL_W]];
    end
  end

  // One register stage per channel. Level samples the pre-edge count, so it
  // lags count by one edge; tick is the rising-edge detect of that level.
  // When en is low the tap is stable, level settles and tick drops to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      tick_q  <= '0;
    end else begin
      level_q <= tap_bit;
      tick_q  <= tap_bit & ~level_q;
    end
  end

  assign bus.count = count_q;
  assign bus.level = level_q;
  assign bus.tick  = tick_q;

`ifdef SLOW_PULSE_STATE_EN
  logic [SEL_W-1:0]      state_q;
  logic [SEL_W-1:0]      state_d;
  logic [NUM_STATES-1:0] onehot_q;
  logic [NUM_STATES-1:0] onehot_d;

  // Advance on the registered tick of channel 0; clear does not touch it.
  always_comb begin
    state_d = state_q;
    if (tick_q[0]) begin
      if (state_q == SEL_W'(NUM_STATES - 1)) begin
        state_d = '0;
      end else begin
        state_d = state_q + 1'b1;
      end
    end
    onehot_d = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      onehot_d[k] = (state_d == SEL_W'(k));
    end
  end

  // Decode is registered alongside state so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      onehot_q <= NUM_STATES'(1);
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
    end
  end

  assign state        = state_q;
  assign state_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_slow_pulse_gen.sv
// tb_slow_pulse_gen
//   Self-checking bench for slow_pulse_gen with CNT_W=8, NUM_CH=2, SEL_W=5.
//   A reference model derives count/level/tick (and the sequencer when
//   SLOW_PULSE_STATE_EN is defined) from the behavioural rules each cycle.
module tb_slow_pulse_gen;
  localparam int CNT_W  = 8;
  localparam int NUM_CH = 2;
  localparam int SEL_W  = 5;
  localparam int NUM_ST = 4;
  localparam int W      = CNT_W + 2 * NUM_CH;

  logic clk;
  logic rst;

  slow_pulse_gen_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

`ifdef SLOW_PULSE_STATE_EN
  logic [SEL_W-1:0]  state;
  logic [NUM_ST-1:0] state_onehot;
  int                m_state;
`endif

  slow_pulse_gen #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .NUM_STATES(NUM_ST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef SLOW_PULSE_STATE_EN
    .state        (state),
    .state_onehot (state_onehot),
`endif
    .bus          (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [1:0]   prev_tick = '0;

  // model state
  int         m_cnt = 0;
  logic [1:0] m_lvl = '0;
  logic [1:0] m_tck = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Square wave of tap s is bit s of the counter; taps past the counter are 0.
  task automatic model_step(input logic r, input logic e, input logic c,
                            input logic [SEL_W-1:0] s0, input logic [SEL_W-1:0] s1);
    int         s[2];
    int         b;
    logic [1:0] nl;
    logic [1:0] nt;
    s[0] = int'(s0);
    s[1] = int'(s1);
    for (int ch = 0; ch < 2; ch++) begin
      b      = (s[ch] < CNT_W) ? ((m_cnt >> s[ch]) & 1) : 0;
      nl[ch] = (b == 1);
      nt[ch] = (b == 1) && !m_lvl[ch];
    end
    if (r) begin
      nl = '0;
      nt = '0;
    end
`ifdef SLOW_PULSE_STATE_EN
    if (r) m_state = 0;
    else if (m_tck[0]) m_state = (m_state + 1) % NUM_ST;
`endif
    m_lvl = nl;
    m_tck = nt;
    if (r || c) m_cnt = 0;
    else if (e) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    exp_q.push_back({8'(m_cnt), m_lvl, m_tck});
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic e, input logic c,
                             input logic [SEL_W-1:0] s0, input logic [SEL_W-1:0] s1);
    logic [W-1:0] exp;
    rst        = r;
    bus.en     = e;
    bus.clear  = c;
    bus.ch_sel = {s1, s0};
    model_step(r, e, c, s0, s1);
    @(posedge clk);
    #1;
    cyc++;
    exp = exp_q.pop_front();
    check("outputs", 32'({bus.count, bus.level, bus.tick}), 32'(exp));
    check("tick_gap", 32'(prev_tick & bus.tick), 32'd0);
    prev_tick = bus.tick;
`ifdef SLOW_PULSE_STATE_EN
    check("state", 32'(state), 32'(m_state));
    check("state_onehot", 32'(state_onehot), 32'(1 << m_state));
`endif
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] cnt;
    logic [1:0] lvl;
    logic [1:0] tck;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int t0;
    int t1;
    int first_t;
    int second_t;
    int rel;

    rst = 1'b1; bus.en = 1'b0; bus.clear = 1'b0; bus.ch_sel = '0;

    // sel0=0, sel1=2 from reset; hand-derived outputs after each edge.
    vecs[0]  = '{1'b1, 1'b0, 8'd1, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 8'd2, 2'b01, 2'b01};
    vecs[2]  = '{1'b1, 1'b0, 8'd3, 2'b00, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, 8'd4, 2'b01, 2'b01};
    vecs[4]  = '{1'b1, 1'b0, 8'd5, 2'b10, 2'b10};
    vecs[5]  = '{1'b1, 1'b0, 8'd6, 2'b11, 2'b01};
    vecs[6]  = '{1'b1, 1'b0, 8'd7, 2'b10, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 8'd8, 2'b11, 2'b01};
    vecs[8]  = '{1'b0, 1'b0, 8'd8, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 8'd8, 2'b00, 2'b00};
    vecs[10] = '{1'b1, 1'b1, 8'd0, 2'b00, 2'b00};
    vecs[11] = '{1'b1, 1'b0, 8'd1, 2'b00, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 8'd2, 2'b01, 2'b01};
    vecs[13] = '{1'b1, 1'b1, 8'd0, 2'b00, 2'b00};
    vecs[14] = '{1'b1, 1'b0, 8'd1, 2'b00, 2'b00};

    #2;
    do_reset();
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_level", 32'(bus.level), 32'd0);
    check("reset_tick", 32'(bus.tick), 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b0, vecs[i].en, vecs[i].clr, 5'd0, 5'd2);
      check("vec_count", 32'(bus.count), 32'(vecs[i].cnt));
      check("vec_level", 32'(bus.level), 32'(vecs[i].lvl));
      check("vec_tick", 32'(bus.tick), 32'(vecs[i].tck));
    end

    // Wrap 255 -> 0 with fast taps; the model flags any extra pulse.
    for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd2);

    // en drop at count 20 with sel0=3: count, level0 and tick0 all hold.
    do_reset();
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, 1'b0, 5'd3, 5'd1);
    check("en_drop_count", 32'(bus.count), 32'd20);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 5'd3, 5'd1);
      check("hold_count", 32'(bus.count), 32'd20);
      check("hold_level0", 32'(bus.level[0]), 32'd0);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b0, 5'd3, 5'd1);
    check("reen_count", 32'(bus.count), 32'd24);
    check("reen_tick0_pre", 32'(bus.tick[0]), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd3, 5'd1);
    check("reen_tick0", 32'(bus.tick[0]), 32'd1);

    // Clear at count 3 with sel0=1 (level0 high): no tick from the clear.
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
    check("pre_clear_level0", 32'(bus.level[0]), 32'd1);
    drive_cycle(1'b0, 1'b1, 1'b1, 5'd1, 5'd1);
    check("clear_count", 32'(bus.count), 32'd0);
    check("clear_level0", 32'(bus.level[0]), 32'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
    check("post_clear_level0", 32'(bus.level[0]), 32'd0);
    check("post_clear_tick0", 32'(bus.tick[0]), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
    check("clear_next_tick0", 32'(bus.tick[0]), 32'd1);

    // Out-of-range tap on channel 0; channel 1 at sel1=1 keeps ticking.
    do_reset();
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 600; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 5'd9, 5'd1);
      t0 += int'(bus.tick[0]) + int'(bus.level[0]);
      t1 += int'(bus.tick[1]);
    end
    check("oor_ch0_quiet", 32'(t0), 32'd0);
    check("oor_ch1_ticks", 32'(t1), 32'd150);

    // Tap switch 0 -> 4 at count 17 (bit4=1, level0=0): immediate tick.
    do_reset();
    for (int i = 0; i < 17; i++) drive_cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    check("switch_pre_level0", 32'(bus.level[0]), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd4, 5'd0);
    check("switch_tick0", 32'(bus.tick[0]), 32'd1);
    first_t  = -1;
    second_t = -1;
    for (int i = 1; i <= 70; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 5'd4, 5'd0);
      if (bus.tick[0]) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
    end
    check("switch_first_tick", 32'(first_t), 32'd31);
    check("switch_period", 32'(second_t - first_t), 32'd32);

`ifdef SLOW_PULSE_STATE_EN
    // Sequencer steps on tick0 and resets mid-sequence.
    do_reset();
    rel = 0;
    while (m_state != 2 && rel < 40) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
      rel++;
    end
    check("seq_reached_2", 32'(state), 32'd2);
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    check("seq_rst_state", 32'(state), 32'd0);
    check("seq_rst_onehot", 32'(state_onehot), 32'd1);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, (i == 7), 5'd0, 5'd0);
`endif

    // Randomized run against the model.
    do_reset();
    begin
      logic [SEL_W-1:0] rs0;
      logic [SEL_W-1:0] rs1;
      rs0 = 5'd0;
      rs1 = 5'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) rs0 = 5'($urandom_range(0, 10));
        if ($urandom_range(0, 49) == 0) rs1 = 5'($urandom_range(0, 10));
        drive_cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 99) == 0, rs0, rs1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
